// File: rtl/nios2_mult_cell_sequencer_if.sv
// Request/response/multiplier-cell signal bundle for nios2_mult_cell_sequencer.
// slave: the sequencer; master: requesters, result consumer and the mult cell.
interface nios2_mult_cell_sequencer_if #(
    parameter int unsigned ID_W = 4
);
    logic            req0_valid;
    logic            req0_ready;
    logic [31:0]     req0_a;
    logic [31:0]     req0_b;
    logic [ID_W-1:0] req0_id;
    logic            req1_valid;
    logic            req1_ready;
    logic [31:0]     req1_a;
    logic [31:0]     req1_b;
    logic [ID_W-1:0] req1_id;
    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_src;
    logic [ID_W-1:0] rsp_id;
    logic [31:0]     rsp_result;
    logic [31:0]     cell_src1;
    logic [31:0]     cell_src2;
    logic            cell_en;
    logic [31:0]     cell_p1;
    logic [31:0]     cell_p2;
    logic [31:0]     cell_p3;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_id,
        input  req1_valid, req1_a, req1_b, req1_id,
        input  rsp_ready, cell_p1, cell_p2, cell_p3,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_src, rsp_id, rsp_result,
        output cell_src1, cell_src2, cell_en
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_id,
        output req1_valid, req1_a, req1_b, req1_id,
        output rsp_ready, cell_p1, cell_p2, cell_p3,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_src, rsp_id, rsp_result,
        input  cell_src1, cell_src2, cell_en
    );
endinterface

// File: rtl/nios2_mult_cell_sequencer.sv
// Shares one 3-product 16x16 mult cell between two requesters; returns low 32 bits of a*b.
// Optional MULT_SEQ_ROUND_ROBIN_EN: round-robin arbitration on contention (default fixed req0 priority).
module nios2_mult_cell_sequencer #(
    parameter int unsigned CELL_LATENCY = 1,
    parameter int unsigned ID_W         = 4
) (
    input logic                        clk,
    input logic                        reset,
    nios2_mult_cell_sequencer_if.slave bus
);
    localparam int unsigned CNT_W = (CELL_LATENCY > 1) ? $clog2(CELL_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CNT_W-1:0] cnt;
    logic            src_q;
    logic [ID_W-1:0] id_q;
    logic            any_valid;
    logic            grant1;
    logic            accept;

`ifdef MULT_SEQ_ROUND_ROBIN_EN
    logic last_grant;
    assign grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
`else
    assign grant1 = bus.req1_valid && !bus.req0_valid;
`endif

    // Ready is gated by reset so it reads 0 while reset is held.
    assign any_valid      = bus.req0_valid || bus.req1_valid;
    assign accept         = (state == IDLE) && !reset && any_valid;
    assign bus.req0_ready = accept && !grant1;
    assign bus.req1_ready = accept && grant1;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)        state_nxt = ISSUE;
            ISSUE:                      state_nxt = WAIT;
            WAIT:    if (cnt == '0)     state_nxt = DONE;
            DONE:    if (bus.rsp_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            src_q          <= 1'b0;
            id_q           <= '0;
            bus.cell_src1  <= '0;
            bus.cell_src2  <= '0;
            bus.cell_en    <= 1'b0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_result <= '0;
            bus.rsp_src    <= 1'b0;
            bus.rsp_id     <= '0;
`ifdef MULT_SEQ_ROUND_ROBIN_EN
            last_grant     <= 1'b1;
`endif
        end else begin
            state       <= state_nxt;
            // cell_en is registered so it is high for exactly the ISSUE cycle.
            bus.cell_en <= accept;
            if (accept) begin
                bus.cell_src1 <= grant1 ? bus.req1_a  : bus.req0_a;
                bus.cell_src2 <= grant1 ? bus.req1_b  : bus.req0_b;
                id_q          <= grant1 ? bus.req1_id : bus.req0_id;
                src_q         <= grant1;
`ifdef MULT_SEQ_ROUND_ROBIN_EN
                last_grant    <= grant1;
`endif
            end
            if (state == ISSUE) begin
                cnt <= CNT_W'(CELL_LATENCY - 1);
            end
            if (state == WAIT) begin
                if (cnt == '0) begin
                    bus.rsp_valid  <= 1'b1;
                    bus.rsp_result <= bus.cell_p1 + ((bus.cell_p2 + bus.cell_p3) << 16);
                    bus.rsp_src    <= src_q;
                    bus.rsp_id     <= id_q;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
            if (state == DONE && bus.rsp_ready) begin
                bus.rsp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_nios2_mult_cell_sequencer.sv
// Directed bench for nios2_mult_cell_sequencer with a behavioural multi-stage mult cell.
module tb_nios2_mult_cell_sequencer;
    localparam int unsigned CL   = 3;
    localparam int unsigned ID_W = 4;

    logic clk;
    logic reset;
    int   cyc;
    int   total;
    int   bad;
    int   en_cnt;
    int   en_run;
    int   en_max_run;

    logic [31:0] s1 [CL];
    logic [31:0] s2 [CL];
    logic [31:0] s3 [CL];

    nios2_mult_cell_sequencer_if #(.ID_W(ID_W)) bus ();

    nios2_mult_cell_sequencer #(
        .CELL_LATENCY(CL),
        .ID_W        (ID_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Cell model: operands captured on the cell_en edge, result emerges CL clocks later.
    always @(posedge clk) begin
        if (bus.cell_en) begin
            s1[0] <= {16'h0, bus.cell_src1[15:0]}  * {16'h0, bus.cell_src2[15:0]};
            s2[0] <= {16'h0, bus.cell_src1[15:0]}  * {16'h0, bus.cell_src2[31:16]};
            s3[0] <= {16'h0, bus.cell_src1[31:16]} * {16'h0, bus.cell_src2[15:0]};
        end
        for (int i = 1; i < CL; i++) begin
            s1[i] <= s1[i-1];
            s2[i] <= s2[i-1];
            s3[i] <= s3[i-1];
        end
    end
    assign bus.cell_p1 = s1[CL-1];
    assign bus.cell_p2 = s2[CL-1];
    assign bus.cell_p3 = s3[CL-1];

    initial begin
        en_cnt = 0; en_run = 0; en_max_run = 0;
    end
    always @(posedge clk) begin
        if (bus.cell_en === 1'b1) begin
            en_cnt <= en_cnt + 1;
            en_run <= en_run + 1;
            if (en_run + 1 > en_max_run) en_max_run <= en_run + 1;
        end else begin
            en_run <= 0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic send(input int req, input logic [31:0] a, input logic [31:0] b,
                        input logic [ID_W-1:0] id, output int acc_cyc, output bit ok);
        if (req == 0) begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_id = id; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_id = id; bus.req1_valid = 1'b1;
        end
        ok = 1'b0;
        acc_cyc = -1;
        for (int i = 0; i < 100 && !ok; i++) begin
            #1;
            if ((req == 0 && bus.req0_ready === 1'b1) || (req == 1 && bus.req1_ready === 1'b1)) begin
                ok = 1'b1;
                acc_cyc = cyc;
            end
            @(negedge clk);
        end
        if (req == 0) bus.req0_valid = 1'b0;
        else          bus.req1_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic [31:0] res, output logic src, output logic [ID_W-1:0] id,
                           output int vcyc, output bit ok);
        ok = 1'b0;
        vcyc = -1;
        res = '0; src = 1'b0; id = '0;
        for (int i = 0; i < 100 && !ok; i++) begin
            #1;
            if (bus.rsp_valid === 1'b1) begin
                ok = 1'b1;
                vcyc = cyc;
                res = bus.rsp_result;
                src = bus.rsp_src;
                id = bus.rsp_id;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        total++; if (bus.req0_ready !== 1'b0) begin bad++; $display("FAIL reset_req0_ready got=%b want=0", bus.req0_ready); end
        total++; if (bus.req1_ready !== 1'b0) begin bad++; $display("FAIL reset_req1_ready got=%b want=0", bus.req1_ready); end
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", bus.rsp_valid); end
        total++; if (bus.rsp_result !== 32'h0) begin bad++; $display("FAIL reset_rsp_result got=%h want=0", bus.rsp_result); end
        total++; if (bus.cell_src1 !== 32'h0 || bus.cell_src2 !== 32'h0) begin bad++; $display("FAIL reset_cell_src got=%h/%h want=0/0", bus.cell_src1, bus.cell_src2); end
        total++; if (bus.cell_en !== 1'b0) begin bad++; $display("FAIL reset_cell_en got=%b want=0", bus.cell_en); end
        total++; if (bus.rsp_src !== 1'b0 || bus.rsp_id !== '0) begin bad++; $display("FAIL reset_rsp_tag got=%b/%h want=0/0", bus.rsp_src, bus.rsp_id); end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int          acc, vc, e0, m0;
        bit          ok_a, ok_r;
        logic [31:0] res;
        logic        src;
        logic [ID_W-1:0] id;
        e0 = en_cnt;
        m0 = en_max_run;
        send(0, 32'd3, 32'd5, 4'd2, acc, ok_a);
        get_rsp(res, src, id, vc, ok_r);
        total++; if (!ok_a || !ok_r) begin bad++; $display("FAIL basic_handshake got=%0d/%0d want=1/1", ok_a, ok_r); end
        total++; if (vc != acc + CL + 2) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", vc - acc, CL + 2); end
        total++; if (res !== 32'd15) begin bad++; $display("FAIL basic_result got=%h want=%h", res, 32'd15); end
        total++; if (src !== 1'b0 || id !== 4'd2) begin bad++; $display("FAIL basic_tag got=%b/%h want=0/2", src, id); end
        total++; if (en_cnt - e0 != 1) begin bad++; $display("FAIL basic_cell_en_count got=%0d want=1", en_cnt - e0); end
        total++; if (en_max_run != 1 && !(m0 == 0 && en_max_run == 1)) begin bad++; $display("FAIL basic_cell_en_width got=%0d want=1", en_max_run); end
    endtask

    task automatic test_patterns;
        logic [31:0]     va [6];
        logic [31:0]     vb [6];
        logic [31:0]     vr [6];
        logic [ID_W-1:0] vi [6];
        int              acc, vc;
        bit              ok_a, ok_r;
        logic [31:0]     res;
        logic            src;
        logic [ID_W-1:0] id;
        va[0] = 32'hFFFF_FFFF; vb[0] = 32'hFFFF_FFFF; vr[0] = 32'h0000_0001; vi[0] = 4'h1;
        va[1] = 32'h0001_2345; vb[1] = 32'h0000_0010; vr[1] = 32'h0012_3450; vi[1] = 4'h7;
        va[2] = 32'h0000_FFFF; vb[2] = 32'h0000_FFFF; vr[2] = 32'hFFFE_0001; vi[2] = 4'hF;
        va[3] = 32'h0001_0001; vb[3] = 32'h0001_0001; vr[3] = 32'h0002_0001; vi[3] = 4'h3;
        va[4] = 32'h8000_0000; vb[4] = 32'h0000_0003; vr[4] = 32'h8000_0000; vi[4] = 4'h0;
        va[5] = 32'hFFFF_FFFE; vb[5] = 32'h0000_0007; vr[5] = 32'hFFFF_FFF2; vi[5] = 4'hA;
        for (int k = 0; k < 6; k++) begin
            send(k % 2, va[k], vb[k], vi[k], acc, ok_a);
            get_rsp(res, src, id, vc, ok_r);
            total++; if (!ok_a || !ok_r) begin bad++; $display("FAIL pattern%0d_handshake got=%0d/%0d want=1/1", k, ok_a, ok_r); end
            total++; if (res !== vr[k]) begin bad++; $display("FAIL pattern%0d_result got=%h want=%h", k, res, vr[k]); end
            total++; if (src !== 1'(k % 2) || id !== vi[k]) begin bad++; $display("FAIL pattern%0d_tag got=%b/%h want=%0d/%h", k, src, id, k % 2, vi[k]); end
        end
    endtask

    task automatic test_back_to_back;
        int  grants [4];
        int  n;
        bit  both;
        int  exp;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        both = 1'b0;
        bus.req0_a = 32'd6; bus.req0_b = 32'd7; bus.req0_id = 4'h4; bus.req0_valid = 1'b1;
        bus.req1_a = 32'd8; bus.req1_b = 32'd9; bus.req1_id = 4'h9; bus.req1_valid = 1'b1;
        for (int i = 0; i < 200 && n < 4; i++) begin
            #1;
            if (bus.req0_ready === 1'b1 && bus.req1_ready === 1'b1) both = 1'b1;
            else if (bus.req0_ready === 1'b1) begin grants[n] = 0; n++; end
            else if (bus.req1_ready === 1'b1) begin grants[n] = 1; n++; end
            @(negedge clk);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        total++; if (n != 4) begin bad++; $display("FAIL arb_grant_count got=%0d want=4", n); end
        total++; if (both) begin bad++; $display("FAIL arb_dual_ready got=1 want=0"); end
        for (int k = 0; k < n; k++) begin
`ifdef MULT_SEQ_ROUND_ROBIN_EN
            exp = k % 2;
`else
            exp = 0;
`endif
            total++; if (grants[k] != exp) begin bad++; $display("FAIL arb_grant%0d got=%0d want=%0d", k, grants[k], exp); end
        end
        repeat (CL + 6) @(negedge clk);
    endtask

    task automatic test_backpressure;
        int          acc, vc, e0;
        bit          ok_a, ok_r;
        logic [31:0] res;
        logic        src;
        logic [ID_W-1:0] id;
        bus.rsp_ready = 1'b0;
        send(0, 32'h0000_1234, 32'h0000_0100, 4'h5, acc, ok_a);
        get_rsp(res, src, id, vc, ok_r);
        total++; if (!ok_a || !ok_r || res !== 32'h0012_3400) begin bad++; $display("FAIL bp_first got=%h want=%h", res, 32'h0012_3400); end
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        e0 = en_cnt;
        for (int i = 0; i < 10; i++) begin
            #1;
            total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_c%0d got=%b want=1", i, bus.rsp_valid); end
            total++; if (bus.rsp_result !== 32'h0012_3400) begin bad++; $display("FAIL bp_result_c%0d got=%h want=%h", i, bus.rsp_result, 32'h0012_3400); end
            total++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_c%0d got=%b%b want=00", i, bus.req0_ready, bus.req1_ready); end
            @(negedge clk);
        end
        total++; if (en_cnt != e0) begin bad++; $display("FAIL bp_cell_en got=%0d want=0", en_cnt - e0); end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b want=0", bus.rsp_valid); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int          acc, vc;
        bit          ok_a, ok_r, seen;
        logic [31:0] res;
        logic        src;
        logic [ID_W-1:0] id;
        send(0, 32'd7, 32'd9, 4'h6, acc, ok_a);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rmid_rsp_valid got=%b want=0", bus.rsp_valid); end
        total++; if (bus.cell_en !== 1'b0) begin bad++; $display("FAIL rmid_cell_en got=%b want=0", bus.cell_en); end
        seen = 1'b0;
        for (int i = 0; i < CL + 4; i++) begin
            @(negedge clk);
            #1;
            if (bus.rsp_valid === 1'b1) seen = 1'b1;
        end
        total++; if (seen) begin bad++; $display("FAIL rmid_abandoned got=1 want=0"); end
        @(negedge clk);
        send(1, 32'h0000_0100, 32'h0000_0100, 4'hC, acc, ok_a);
        get_rsp(res, src, id, vc, ok_r);
        total++; if (!ok_a || !ok_r) begin bad++; $display("FAIL rmid_next_handshake got=%0d/%0d want=1/1", ok_a, ok_r); end
        total++; if (res !== 32'h0001_0000 || src !== 1'b1 || id !== 4'hC) begin bad++; $display("FAIL rmid_next got=%h/%b/%h want=00010000/1/c", res, src, id); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_id = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_id = '0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_patterns();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
